// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision accumulate sequencer.
package fp_pkg;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    typedef enum logic [1:0] {
        S_FIRST,
        S_NEXT,
        S_ADD,
        S_DONE
    } state_t;

    // Negate an IEEE-754 single by flipping its sign bit.
    function automatic logic [FP_W-1:0] fp_neg(input logic [FP_W-1:0] x);
        return {~x[FP_W-1], x[FP_W-2:0]};
    endfunction

endpackage

// File: rtl/fp_accum_seq.sv
// Sequencer that feeds an external combinational FP add/sub unit and reduces
// each valid/ready operand group to one sum, emitted on a valid/ready output.
module fp_accum_seq
    import fp_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic [FP_W-1:0]  add_a,
    output logic [FP_W-1:0]  add_b,
    output logic             add_f,
    input  logic [FP_W-1:0]  add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc
);

    state_t           state_q;
    logic [FP_W-1:0]  acc_q;
    logic [FP_W-1:0]  opb_q;
    logic             opf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    logic             trunc_q;
    logic             out_valid_q;

    logic [CNT_W-1:0] cnt_inc;
    logic             at_max;

    assign cnt_inc = cnt_q + 1'b1;
    assign at_max  = (cnt_inc == CNT_W'(MAX_LEN));

    // Operands are accepted only while waiting for the first or a further element.
    always_comb begin
        in_ready = 1'b0;
        if (state_q == S_FIRST || state_q == S_NEXT) begin
            in_ready = 1'b1;
        end
    end

    assign add_a     = acc_q;
    assign add_b     = opb_q;
    assign add_f     = opf_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_count = cnt_q;
    assign out_trunc = trunc_q;

    // Group FSM plus accumulator/operand registers; clr overrides every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FIRST;
            acc_q       <= '0;
            opb_q       <= '0;
            opf_q       <= 1'b0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            trunc_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            state_q     <= S_FIRST;
            cnt_q       <= '0;
            trunc_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_FIRST: begin
                    if (in_valid) begin
                        // The adder has no zero operand, so the first element is loaded directly.
                        acc_q <= in_sub ? fp_neg(in_data) : in_data;
                        cnt_q <= CNT_W'(1);
                        if (in_last) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    if (in_valid) begin
                        opb_q   <= in_data;
                        opf_q   <= in_sub;
                        cnt_q   <= cnt_inc;
                        last_q  <= in_last || at_max;
                        trunc_q <= !in_last && at_max;
                        state_q <= S_ADD;
                    end
                end
                S_ADD: begin
                    acc_q <= add_s;
                    if (last_q) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= S_NEXT;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        cnt_q       <= '0;
                        trunc_q     <= 1'b0;
                        out_valid_q <= 1'b0;
                        state_q     <= S_FIRST;
                    end
                end
                default: begin
                    state_q <= S_FIRST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Bench for fp_accum_seq: behavioural FP adder on the adder port, real-valued
// group-sum model, and a per-cycle output monitor.
module tb_fp_accum_seq;

    localparam int ML = 4;
    localparam int CW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst_n, clr, in_valid, in_ready, in_sub, in_last;
    logic [31:0]   in_data, add_a, add_b, add_s, out_data;
    logic          add_f, out_valid, out_ready, out_trunc;
    logic [CW-1:0] out_count;

    int  tests = 0;
    int  fails = 0;
    int  rdy_mode = 0;      // 0: always ready, 1: random, 2: directed
    logic rdy_rand = 1'b1;
    logic rdy_dir  = 1'b0;

    typedef struct {
        logic [31:0] d;
        int          c;
        logic        t;
    } res_t;
    res_t exp_q[$];
    real  m_sum = 0.0;
    int   m_cnt = 0;

    always #5 clk = ~clk;

    assign out_ready = (rdy_mode == 2) ? rdy_dir : (rdy_mode == 1) ? rdy_rand : 1'b1;

    fp_accum_seq #(.MAX_LEN(ML)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sub(in_sub), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_f(add_f), .add_s(add_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_trunc(out_trunc)
    );

    function automatic real fp_dec(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    // Exact for the half-integer magnitudes this bench uses.
    function automatic logic [31:0] fp_enc(input real r);
        real         m;
        int          e;
        logic        s;
        longint      man;
        logic [63:0] mb;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        man = longint'((m - 1.0) * 8388608.0);
        mb  = 64'(man);
        return {s, 8'(e + 127), mb[22:0]};
    endfunction

    // Behavioural stand-in for the combinational adder at the parent level.
    always_comb begin
        add_s = fp_enc(fp_dec(add_a) + (add_f ? -fp_dec(add_b) : fp_dec(add_b)));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_elem(input logic [31:0] d, input logic s, input logic l);
        real  v;
        res_t r;
        v = fp_dec(d);
        m_sum = m_sum + (s ? -v : v);
        m_cnt++;
        if (l || m_cnt == ML) begin
            r.d = fp_enc(m_sum);
            r.c = m_cnt;
            r.t = !l && (m_cnt == ML);
            exp_q.push_back(r);
            m_sum = 0.0;
            m_cnt = 0;
        end
    endtask

    task automatic model_drop();
        m_sum = 0.0;
        m_cnt = 0;
    endtask

    // Presents one element, waits (bounded) for acceptance, then updates the model.
    task automatic send(input logic [31:0] d, input logic s, input logic l, output int waits);
        in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
        waits = 0;
        while (!in_ready && waits < 100) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 100) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            model_elem(d, s, l);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        chk(name, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    logic          hold_prev = 1'b0;
    logic [31:0]   prev_d;
    logic [CW-1:0] prev_c;
    logic          prev_t;

    // Random out_ready, changed well away from the sampling edge.
    always @(posedge clk) begin
        #2;
        rdy_rand = 1'($urandom_range(0, 1));
    end

    // Output monitor: result check on every handshake, stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, prev_d);
                chk("hold_count", 32'(out_count), 32'(prev_c));
                chk("hold_trunc", 32'(out_trunc), 32'(prev_t));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    chk("out_data", out_data, r.d);
                    chk("out_count", 32'(out_count), 32'(r.c));
                    chk("out_trunc", 32'(out_trunc), 32'(r.t));
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_d = out_data;
            prev_c = out_count;
            prev_t = out_trunc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_trunc", 32'(out_trunc), 32'd0);
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_add_b", add_b, 32'h0);
        chk("rst_add_f", 32'(add_f), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1.0 + 2.0, latency check
        send(32'h3F800000, 1'b0, 1'b0, w);
        send(32'h40000000, 1'b0, 1'b1, w);
        chk("model_g1_data", exp_q[$].d, 32'h40400000);
        chk("g1_valid_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("g1_valid_edge", 32'(out_valid), 32'd1);
        chk("g1_data", out_data, 32'h40400000);
        wait_idle("g1_drain");

        // 3.0 - 1.0 - 0.5
        send(32'h40400000, 1'b0, 1'b0, w);
        send(32'h3F800000, 1'b1, 1'b0, w);
        send(32'h3F000000, 1'b1, 1'b1, w);
        chk("model_g2_data", exp_q[$].d, 32'h3FC00000);
        chk("model_g2_count", 32'(exp_q[$].c), 32'd3);
        wait_idle("g2_drain");

        // single negated element, no adder cycle
        send(32'h40000000, 1'b1, 1'b1, w);
        chk("model_g3_data", exp_q[$].d, 32'hC0000000);
        chk("g3_valid_now", 32'(out_valid), 32'd1);
        chk("g3_data", out_data, 32'hC0000000);
        wait_idle("g3_drain");

        // truncation at MAX_LEN, then remainder group
        for (int i = 0; i < 6; i++) begin
            send(32'h3F800000, 1'b0, (i == 5), w);
            if (i == 3) begin
                chk("model_trunc_data", exp_q[$].d, 32'h40800000);
                chk("model_trunc_count", 32'(exp_q[$].c), 32'd4);
                chk("model_trunc_flag", 32'(exp_q[$].t), 32'd1);
            end
        end
        chk("model_rest_data", exp_q[$].d, 32'h40000000);
        chk("model_rest_count", 32'(exp_q[$].c), 32'd2);
        wait_idle("trunc_drain");

        // in_last exactly at MAX_LEN: not truncated
        for (int i = 0; i < 4; i++) send(32'h3F800000, 1'b0, (i == 3), w);
        chk("model_last_at_max", 32'(exp_q[$].t), 32'd0);
        wait_idle("last_at_max_drain");

        // backpressure hold, then single-cycle pop
        rdy_mode = 2; rdy_dir = 1'b0;
        send(32'h3F800000, 1'b0, 1'b1, w);
        wait_valid("hold_wait");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        rdy_dir = 1'b1;
        @(posedge clk); #1;
        rdy_dir = 1'b0;
        chk("pop_in_ready", 32'(in_ready), 32'd1);
        chk("pop_out_valid", 32'(out_valid), 32'd0);
        send(32'h40000000, 1'b0, 1'b1, w);
        chk("accept_after_pop", 32'(w), 32'd0);
        rdy_mode = 0;
        wait_idle("hold_drain");

        // clr in S_ADD mid-group
        send(32'h3F800000, 1'b0, 1'b0, w);
        send(32'h40000000, 1'b0, 1'b0, w);
        clr = 1'b1;
        model_drop();
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        send(32'h3F800000, 1'b0, 1'b1, w);
        chk("model_after_clr", exp_q[$].d, 32'h3F800000);
        wait_idle("clr_drain");

        // async reset in S_ADD mid-group
        send(32'h3F800000, 1'b0, 1'b0, w);
        send(32'h40000000, 1'b0, 1'b0, w);
        rst_n = 1'b0;
        model_drop();
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'h3F800000, 1'b0, 1'b1, w);
        chk("model_after_rst_count", 32'(exp_q[$].c), 32'd1);
        wait_idle("rst_drain");

        // randomized groups with random backpressure and input gaps
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] d;
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            d = fp_enc(real'($urandom_range(1, 2000)) * 0.5);
            send(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), w);
        end
        send(32'h3F800000, 1'b0, 1'b1, w);
        rdy_mode = 0;
        wait_idle("random_drain");
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
